// File: rtl/cbus_mem_responder.sv
// cbus_pkg / cbus_mem_responder
//
// Responder end of the cbus request/response protocol. Serves single and
// burst reads/writes out of an internal 64-bit word RAM after a programmable
// access latency. Used as page-table/backing memory in unit benches and as
// on-chip scratch memory.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset (RAM contents are kept)
//   creq       request  : valid, is_write, size, addr, strobe, data, len, burst
//   cresp      response : ready, last, data
//   init_we    backdoor preload write enable (only honoured while idle)
//   init_addr  backdoor word index
//   init_data  backdoor word data

package cbus_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1
    } cbus_burst_e;

    // len encodes beats-1
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t                    creq,
    output cbus_resp_t                   cresp,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [63:0]                  init_data
);

    localparam int         ADDR_W   = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_r;
    logic [3:0]          lat_cnt_r;
    logic [3:0]          beat_cnt_r;
    logic [3:0]          len_r;
    logic [ADDR_W-1:0]   idx_r;
    logic                is_write_r;
    cbus_burst_e         burst_r;

    logic [63:0]         mem_r [MEM_WORDS];

    logic                beat_active_s;
    logic                last_beat_s;
    logic                wr_en_s;
    logic                init_en_s;
    logic                unused_s;

    // A beat only happens while the initiator still holds valid; dropping it
    // is an abort and suppresses ready/last and the write for that cycle.
    assign beat_active_s = (state_r == ST_BEAT) && creq.valid;
    assign last_beat_s   = beat_active_s && (beat_cnt_r == len_r);
    assign wr_en_s       = beat_active_s && is_write_r;
    assign init_en_s     = (state_r == ST_IDLE) && init_we;

    // size and the byte/upper address bits do not take part in addressing
    assign unused_s = ^{creq.size, creq.addr[63:3+ADDR_W], creq.addr[2:0]};

    // Request sequencing: accept, count latency, step beats, turnaround
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= 4'd0;
            beat_cnt_r <= 4'd0;
            len_r      <= 4'd0;
            idx_r      <= '0;
            is_write_r <= 1'b0;
            burst_r    <= BURST_FIXED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (creq.valid) begin
                        idx_r      <= creq.addr[3 +: ADDR_W];
                        len_r      <= creq.len;
                        burst_r    <= creq.burst;
                        is_write_r <= creq.is_write;
                        lat_cnt_r  <= LAT_INIT;
                        beat_cnt_r <= 4'd0;
                        state_r    <= (LATENCY == 0) ? ST_BEAT : ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!creq.valid) begin
                        lat_cnt_r <= 4'd0;
                        state_r   <= ST_IDLE;
                    end else if (lat_cnt_r <= 4'd1) begin
                        lat_cnt_r <= 4'd0;
                        state_r   <= ST_BEAT;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                ST_BEAT: begin
                    if (!creq.valid) begin
                        beat_cnt_r <= 4'd0;
                        state_r    <= ST_IDLE;
                    end else if (beat_cnt_r == len_r) begin
                        beat_cnt_r <= 4'd0;
                        state_r    <= ST_DONE;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + 4'd1;
                        // index wraps naturally because MEM_WORDS is a power of two
                        if (burst_r == BURST_INCR) begin
                            idx_r <= idx_r + ADDR_W'(1);
                        end else begin
                            idx_r <= idx_r;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM write port: bus write beats (byte strobed) or backdoor preload;
    // deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 8; i++) begin
                if (creq.strobe[i]) begin
                    mem_r[idx_r][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end else if (init_en_s) begin
            mem_r[init_addr] <= init_data;
        end
    end

    // Response: read data is taken straight from the array on each read beat
    always_comb begin
        cresp       = '0;
        cresp.ready = beat_active_s;
        cresp.last  = last_beat_s;
        if (beat_active_s && !is_write_r) begin
            cresp.data = mem_r[idx_r];
        end else begin
            cresp.data = 64'd0;
        end
    end

endmodule
